// File: rtl/fp_div_mantissa_iter.sv
// Radix-2 restoring divider for normalized FP mantissas; emits the normalized quotient plus L/G/R/S for the rounder.
// Optional FPU_DIV_EARLY_TERM_EN: stop iterating once the partial remainder reaches zero.
module fp_div_mantissa_iter #(
    parameter int MANT_W = 24
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              start_i,
    input  logic [MANT_W-1:0] mant_a_i,
    input  logic [MANT_W-1:0] mant_b_i,
    input  logic              sign_a_i,
    input  logic              sign_b_i,
    input  logic [2:0]        rm_i,
    output logic              busy_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [MANT_W-1:0] mant_q_o,
    output logic              exp_dec_o,
    output logic [3:0]        lgrs_o,
    output logic              sign_o,
    output logic [2:0]        rm_o
);

    localparam int QBITS = MANT_W + 3;
    localparam int CNT_W = $clog2(QBITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_NORM,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [MANT_W:0]   rem_reg;
    logic [MANT_W-1:0] divisor_reg;
    logic [QBITS-1:0]  q_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              sign_reg;
    logic [2:0]        rm_reg;

    logic [MANT_W-1:0] mant_q_reg;
    logic              exp_dec_reg;
    logic [3:0]        lgrs_reg;
    logic              sign_out_reg;
    logic [2:0]        rm_out_reg;
    logic              out_valid_reg;

    // One restoring step: trial subtract, keep it only if non-negative, then shift.
    logic [MANT_W:0]   divisor_ext;
    logic [MANT_W:0]   diff;
    logic              q_bit;
    logic [MANT_W:0]   rem_sub;
    logic [MANT_W:0]   rem_next;
    logic [QBITS-1:0]  q_next;
    logic              last_iter;
    logic              div_done;

    assign divisor_ext = {1'b0, divisor_reg};
    assign diff        = rem_reg - divisor_ext;
    assign q_bit       = (rem_reg >= divisor_ext);
    assign rem_sub     = q_bit ? diff : rem_reg;
    assign rem_next    = rem_sub << 1;
    assign last_iter   = (cnt_reg == CNT_W'(QBITS - 1));

    // Quotient bits are written in place (MSB first) so unvisited bits stay zero.
    generate
        for (genvar gi = 0; gi < QBITS; gi++) begin : g_qbit
            assign q_next[gi] = (cnt_reg == CNT_W'(QBITS - 1 - gi)) ? q_bit : q_reg[gi];
        end
    endgenerate

`ifdef FPU_DIV_EARLY_TERM_EN
    assign div_done = last_iter || (q_bit && (diff == '0));
`else
    assign div_done = last_iter;
`endif

    // Normalization: a quotient below 1.0 is shifted left by one bit.
    logic              norm_hi;
    logic [MANT_W-1:0] mant_norm;
    logic              g_bit;
    logic              r_bit;
    logic              s_bit;

    assign norm_hi   = q_reg[QBITS-1];
    assign mant_norm = norm_hi ? q_reg[QBITS-1:3] : q_reg[QBITS-2:2];
    assign g_bit     = norm_hi ? q_reg[2] : q_reg[1];
    assign r_bit     = norm_hi ? q_reg[1] : q_reg[0];
    assign s_bit     = (norm_hi & q_reg[0]) | (rem_reg != '0);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg     <= S_IDLE;
            rem_reg       <= '0;
            divisor_reg   <= '0;
            q_reg         <= '0;
            cnt_reg       <= '0;
            sign_reg      <= 1'b0;
            rm_reg        <= '0;
            mant_q_reg    <= '0;
            exp_dec_reg   <= 1'b0;
            lgrs_reg      <= '0;
            sign_out_reg  <= 1'b0;
            rm_out_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else if (flush_i) begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        rem_reg     <= {1'b0, mant_a_i};
                        divisor_reg <= mant_b_i;
                        q_reg       <= '0;
                        cnt_reg     <= '0;
                        sign_reg    <= sign_a_i ^ sign_b_i;
                        rm_reg      <= rm_i;
                        state_reg   <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_reg <= rem_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (div_done) begin
                        state_reg <= S_NORM;
                    end
                end
                S_NORM: begin
                    mant_q_reg    <= mant_norm;
                    exp_dec_reg   <= ~norm_hi;
                    lgrs_reg      <= {mant_norm[0], g_bit, r_bit, s_bit};
                    sign_out_reg  <= sign_reg;
                    rm_out_reg    <= rm_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_reg != S_IDLE);
    assign out_valid_o = out_valid_reg;
    assign mant_q_o    = mant_q_reg;
    assign exp_dec_o   = exp_dec_reg;
    assign lgrs_o      = lgrs_reg;
    assign sign_o      = sign_out_reg;
    assign rm_o        = rm_out_reg;

endmodule

// File: tb/tb_fp_div_mantissa_iter.sv
// Directed bench for fp_div_mantissa_iter (MANT_W=24): vectors, backpressure, flush, mid-op reset, back-to-back.
module tb_fp_div_mantissa_iter;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        start_i = 1'b0;
    logic [23:0] mant_a_i = '0;
    logic [23:0] mant_b_i = '0;
    logic        sign_a_i = 1'b0;
    logic        sign_b_i = 1'b0;
    logic [2:0]  rm_i = '0;
    logic        busy_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [23:0] mant_q_o;
    logic        exp_dec_o;
    logic [3:0]  lgrs_o;
    logic        sign_o;
    logic [2:0]  rm_o;

    int errors = 0;
    int checks = 0;

    fp_div_mantissa_iter #(.MANT_W(24)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .start_i     (start_i),
        .mant_a_i    (mant_a_i),
        .mant_b_i    (mant_b_i),
        .sign_a_i    (sign_a_i),
        .sign_b_i    (sign_b_i),
        .rm_i        (rm_i),
        .busy_o      (busy_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .mant_q_o    (mant_q_o),
        .exp_dec_o   (exp_dec_o),
        .lgrs_o      (lgrs_o),
        .sign_o      (sign_o),
        .rm_o        (rm_o)
    );

    always #5 clk = ~clk;

    // Directed vectors with hand-derived quotients.
    localparam int NVEC = 6;
    logic [23:0] vec_a    [NVEC] = '{24'h800000, 24'h800000, 24'hFFFFFF, 24'hC00000, 24'h800000, 24'hA00000};
    logic [23:0] vec_b    [NVEC] = '{24'h800000, 24'hC00000, 24'h800000, 24'h800000, 24'hA00000, 24'h800000};
    logic        vec_sa   [NVEC] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        vec_sb   [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  vec_rm   [NVEC] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b111};
    logic [23:0] exp_q    [NVEC] = '{24'h800000, 24'hAAAAAA, 24'hFFFFFF, 24'hC00000, 24'hCCCCCC, 24'hA00000};
    logic        exp_dec  [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  exp_lgrs [NVEC] = '{4'b0000, 4'b0101, 4'b1000, 4'b0000, 4'b0111, 4'b0000};
    logic        exp_sign [NVEC] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef FPU_DIV_EARLY_TERM_EN
    int          exp_lat  [NVEC] = '{2, 28, 25, 3, 28, 4};
`else
    int          exp_lat  [NVEC] = '{28, 28, 28, 28, 28, 28};
`endif

    // Issue one start pulse and count cycles until out_valid_o (bounded).
    task automatic drive_op(input logic [23:0] a, input logic [23:0] b, input logic sa,
                            input logic sb, input logic [2:0] rm, output int lat);
        @(negedge clk);
        mant_a_i = a;
        mant_b_i = b;
        sign_a_i = sa;
        sign_b_i = sb;
        rm_i     = rm;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({busy_o, out_valid_o, mant_q_o, exp_dec_o, lgrs_o, sign_o, rm_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b valid=%b q=%h dec=%b lgrs=%b sign=%b rm=%b, want all zero",
                     busy_o, out_valid_o, mant_q_o, exp_dec_o, lgrs_o, sign_o, rm_o);
        end
    endtask

    task automatic test_vectors();
        int lat;
        for (int i = 0; i < NVEC; i++) begin
            drive_op(vec_a[i], vec_b[i], vec_sa[i], vec_sb[i], vec_rm[i], lat);
            checks++;
            if (lat !== exp_lat[i]) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, exp_lat[i]);
            end
            checks++;
            if (mant_q_o !== exp_q[i] || exp_dec_o !== exp_dec[i] || lgrs_o !== exp_lgrs[i]) begin
                errors++;
                $display("FAIL vec%0d_quot: got q=%h dec=%b lgrs=%b want q=%h dec=%b lgrs=%b",
                         i, mant_q_o, exp_dec_o, lgrs_o, exp_q[i], exp_dec[i], exp_lgrs[i]);
            end
            checks++;
            if (sign_o !== exp_sign[i] || rm_o !== vec_rm[i]) begin
                errors++;
                $display("FAIL vec%0d_sign_rm: got sign=%b rm=%b want sign=%b rm=%b",
                         i, sign_o, rm_o, exp_sign[i], vec_rm[i]);
            end
            handshake();
            checks++;
            if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_release: got valid=%b busy=%b want 0 0", i, out_valid_o, busy_o);
            end
            $display("vec%0d a=%h b=%h -> q=%h dec=%b lgrs=%b sign=%b rm=%b lat=%0d",
                     i, vec_a[i], vec_b[i], mant_q_o, exp_dec_o, lgrs_o, sign_o, rm_o, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        drive_op(24'h800000, 24'hC00000, 1'b0, 1'b1, 3'b001, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                mant_a_i = 24'h800000;
                mant_b_i = 24'h800000;
                start_i  = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (out_valid_o !== 1'b1 || busy_o !== 1'b1 || mant_q_o !== 24'hAAAAAA || lgrs_o !== 4'b0101) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b busy=%b q=%h lgrs=%b want 1 1 aaaaaa 0101",
                         i, out_valid_o, busy_o, mant_q_o, lgrs_o);
            end
        end
        start_i = 1'b0;
        handshake();
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b busy=%b want 0 0", out_valid_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || mant_q_o !== 24'hAAAAAA) begin
            errors++;
            $display("FAIL bp_not_queued: got busy=%b q=%h want 0 aaaaaa", busy_o, mant_q_o);
        end
        $display("backpressure held 5 cycles, q=%h", mant_q_o);
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        // In flight: last result (AAAAAA) must survive the abort.
        @(negedge clk);
        mant_a_i = 24'h800000;
        mant_b_i = 24'hC00000;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || mant_q_o !== 24'hAAAAAA) begin
            errors++;
            $display("FAIL flush_div: got busy=%b valid=%b q=%h want 0 0 aaaaaa", busy_o, out_valid_o, mant_q_o);
        end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen);
        end
        // Flush and start together while idle: flush wins.
        mant_a_i = 24'hC00000;
        mant_b_i = 24'h800000;
        start_i  = 1'b1;
        flush_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        flush_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_start: got busy=%b want 0", busy_o);
        end
        drive_op(24'h800000, 24'hA00000, 1'b0, 1'b0, 3'b011, lat);
        checks++;
        if (mant_q_o !== 24'hCCCCCC || lgrs_o !== 4'b0111 || exp_dec_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_new_op: got q=%h lgrs=%b dec=%b want cccccc 0111 1", mant_q_o, lgrs_o, exp_dec_o);
        end
        // Flush in DONE with ready and start also high.
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        start_i     = 1'b1;
        @(negedge clk);
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || mant_q_o !== 24'hCCCCCC) begin
            errors++;
            $display("FAIL flush_done: got valid=%b busy=%b q=%h want 0 0 cccccc", out_valid_o, busy_o, mant_q_o);
        end
        $display("flush checks done, q=%h", mant_q_o);
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        @(negedge clk);
        mant_a_i = 24'h800000;
        mant_b_i = 24'hC00000;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        reset_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || mant_q_o !== 24'h0 || lgrs_o !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b valid=%b q=%h lgrs=%b want 0 0 000000 0000",
                     busy_o, out_valid_o, mant_q_o, lgrs_o);
        end
        @(negedge clk);
        reset_i = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_valid: got %0d valid cycles want 0", seen);
        end
        drive_op(24'h800000, 24'hC00000, 1'b1, 1'b0, 3'b110, lat);
        checks++;
        if (mant_q_o !== 24'hAAAAAA || lgrs_o !== 4'b0101 || sign_o !== 1'b1 || rm_o !== 3'b110) begin
            errors++;
            $display("FAIL reset_new_op: got q=%h lgrs=%b sign=%b rm=%b want aaaaaa 0101 1 110",
                     mant_q_o, lgrs_o, sign_o, rm_o);
        end
        handshake();
        $display("mid-op reset recovered, q=%h", mant_q_o);
    endtask

    task automatic test_back_to_back();
        int lat;
        drive_op(24'hC00000, 24'h800000, 1'b0, 1'b0, 3'b000, lat);
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        // Start immediately in the cycle after the handshake.
        mant_a_i = 24'hFFFFFF;
        mant_b_i = 24'h800000;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b want 1", busy_o);
        end
        lat = 0;
        while (!out_valid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (mant_q_o !== 24'hFFFFFF || lgrs_o !== 4'b1000 || exp_dec_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: got q=%h lgrs=%b dec=%b want ffffff 1000 0", mant_q_o, lgrs_o, exp_dec_o);
        end
        handshake();
        $display("back-to-back second op q=%h lat=%0d", mant_q_o, lat);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset_i = 1'b1;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
